load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   MEM-stage initiator for the byte-addressed data memory (combinational read, posedge write, word-wide, no byte enables).
//   Executes RV32I lb/lh/lw/lbu/lhu/sb/sh/sw: aligns and extends load data, builds sub-word stores by read-modify-write.
//   Flags misaligned, out-of-range and illegal-funct3 requests without touching memory.
// PARAMETERS
//   MEM_BYTES  2048  data memory size in bytes; a request with req_addr >= MEM_BYTES is an error
// PORTS
//   clk            in   1   clock; all state updates on posedge
//   rst_n          in   1   asynchronous, active-low reset
//   req_valid      in   1   request present
//   req_ready      out  1   unit idle, can accept; transfer when req_valid && req_ready
//   req_we         in   1   1=store, 0=load
//   req_funct3     in   3   RV32I funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   req_addr       in   32  byte address
//   req_wdata      in   32  store data (low byte/half used for sb/sh)
//   resp_valid     out  1   one-cycle completion pulse, no backpressure
//   resp_rdata     out  32  load result, extended; 0 for stores and errors
//   resp_err       out  1   request rejected (valid only with resp_valid)
//   mem_addr       out  32  word-aligned address to data memory
//   mem_wd         out  32  write data to data memory
//   mem_memwrite   out  1   write strobe to data memory
//   mem_rd         in   32  read data from data memory (combinational from mem_addr)
// BEHAVIOUR
//   Reset (async, immediate): state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; mem_addr=0, mem_wd=0, mem_memwrite=0.
//   req_ready = (state==IDLE). On accept latch we, funct3, addr, wdata; mem_addr = {addr[31:2],2'b00}, held until next accept.
//   Error check at accept: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0; funct3 011/110/111; store funct3 1xx; addr>=MEM_BYTES.
//   FSM: IDLE -> ERR-path: RESP | ACCESS.  ACCESS -> RESP (load, sw) | WRITE (sb, sh).  WRITE -> RESP.  RESP -> IDLE.
//   ACCESS: load: sample mem_rd, select byte addr[1:0] / half addr[1], sign-extend (lb/lh) or zero-extend (lbu/lhu) into resp_rdata.
//           sw: mem_memwrite=1, mem_wd=wdata (memory writes at end of this cycle).
//           sb/sh: sample mem_rd, merge low byte into lane addr[1:0] / low half into lane addr[1], other lanes preserved -> merged reg.
//   WRITE: mem_memwrite=1, mem_wd=merged word.
//   RESP: resp_valid=1 for exactly one cycle; resp_err set on error path; resp_rdata=0 on stores/errors.
//   mem_memwrite decoded from state only: high solely in ACCESS(sw) or WRITE; never on error path; exactly one strobe cycle per store.
//   Latency (cycles from accepting edge to resp_valid cycle): error 1, load 2, sw 2, sb/sh 3. Throughput: next accept in cycle after RESP.
//   resp_rdata/resp_err hold their values outside RESP; only resp_valid qualifies them.
//   Reset mid-operation: abandon request, no response; mem_memwrite drops asynchronously, so an in-flight sb/sh write does not occur.
//   Requests offered while req_ready=0 are ignored (requester holds req_valid).
// TESTING
//   sw 0xDACBF567 @0, then lw @0 -> resp_rdata=0xDACBF567, err=0; sw resp 2 cycles after accept, one memwrite cycle.
//   sw 0xCA30B91E @4, sb wdata=0x000000AB @5, lw @4 -> 0xCA30AB1E; sb resp 3 cycles after accept, memwrite high only in WRITE.
//   From 0xCA30AB1E @4: lb @7 -> 0xFFFFFFCA; lbu @7 -> 0x000000CA; lb @6 -> 0x00000030; lh @6 -> 0xFFFFCA30; lhu @4 -> 0x0000AB1E.
//   lw @2, sh @3, lw @2048, funct3=011 -> each resp_err=1, resp_rdata=0, resp 1 cycle after accept, mem_memwrite never high, memory unchanged.
//   sh 0x1234 @6 over 0xCA30AB1E, assert rst_n=0 during WRITE -> memwrite falls at once, lw @4 after release still 0xCA30AB1E, req_ready=1.
//   req_valid held high for 3 loads back-to-back -> req_ready low in ACCESS/RESP, accepts exactly 3, one resp_valid pulse per request, in order.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// A request transfers on a posedge where req_valid && req_ready; resp_valid is a one-cycle pulse with no backpressure.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        mem_memwrite;
   logic [31:0] mem_rd;

   // slave: the load/store unit itself
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_memwrite
   );

   // master: the pipeline issuing requests together with the data memory
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_memwrite
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I MEM-stage load/store unit: aligned loads with extension, sub-word stores by
// read-modify-write against a word-wide memory, error reporting without memory access.
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 2048
) (
   input  logic              clk,
   input  logic              rst_n,
   load_store_unit_if.slave  bus,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [31:0] wdata_q;
   logic [31:0] merged_q;
   logic [31:0] mem_addr_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        accept;
   logic        req_err;
   logic        is_sw;
   logic [31:0] load_val;
   logic [31:0] merge_val;

   assign accept = bus.req_valid && (state == IDLE);
   assign is_sw  = we_q && (f3_q[1:0] == 2'b10);

   // Illegal encodings, stores with funct3[2] set, misalignment, and out-of-range.
   always_comb begin
      req_err = 1'b0;
      if (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 || bus.req_funct3 == 3'b111)
         req_err = 1'b1;
      if (bus.req_we && bus.req_funct3[2])
         req_err = 1'b1;
      if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
         req_err = 1'b1;
      if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
         req_err = 1'b1;
      if (bus.req_addr >= MEM_BYTES)
         req_err = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = req_err ? RESP : ACCESS;
         ACCESS:  state_nxt = (!we_q || is_sw) ? RESP : WRITE;
         WRITE:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'h00;
      case (off_q)
         2'd0: b = bus.mem_rd[7:0];
         2'd1: b = bus.mem_rd[15:8];
         2'd2: b = bus.mem_rd[23:16];
         2'd3: b = bus.mem_rd[31:24];
         default: b = 8'h00;
      endcase
      h = off_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
      case (f3_q)
         3'b000:  load_val = {{24{b[7]}}, b};
         3'b001:  load_val = {{16{h[15]}}, h};
         3'b100:  load_val = {24'h0, b};
         3'b101:  load_val = {16'h0, h};
         default: load_val = bus.mem_rd;
      endcase
   end

   // Replace only the addressed lane; the rest of the word comes back from memory unchanged.
   always_comb begin
      merge_val = bus.mem_rd;
      if (f3_q[0]) begin
         if (off_q[1]) merge_val[31:16] = wdata_q[15:0];
         else          merge_val[15:0]  = wdata_q[15:0];
      end else begin
         case (off_q)
            2'd0: merge_val[7:0]   = wdata_q[7:0];
            2'd1: merge_val[15:8]  = wdata_q[7:0];
            2'd2: merge_val[23:16] = wdata_q[7:0];
            2'd3: merge_val[31:24] = wdata_q[7:0];
            default: merge_val = bus.mem_rd;
         endcase
      end
   end

   // Response registers change only on the edge entering RESP, so they hold elsewhere.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         off_q      <= 2'b00;
         wdata_q    <= 32'h0;
         merged_q   <= 32'h0;
         mem_addr_q <= 32'h0;
         rdata_q    <= 32'h0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q       <= bus.req_we;
                  f3_q       <= bus.req_funct3;
                  off_q      <= bus.req_addr[1:0];
                  wdata_q    <= bus.req_wdata;
                  mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                  if (req_err) begin
                     rdata_q <= 32'h0;
                     err_q   <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (!we_q) begin
                  rdata_q <= load_val;
                  err_q   <= 1'b0;
               end else if (is_sw) begin
                  rdata_q <= 32'h0;
                  err_q   <= 1'b0;
               end else begin
                  merged_q <= merge_val;
               end
            end
            WRITE: begin
               rdata_q <= 32'h0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready    = (state == IDLE);
   assign bus.resp_valid   = (state == RESP);
   assign bus.resp_rdata   = rdata_q;
   assign bus.resp_err     = err_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_memwrite = (state == ACCESS && is_sw) || (state == WRITE);
   assign bus.mem_wd       = (state == ACCESS && is_sw) ? wdata_q :
                             (state == WRITE)           ? merged_q : 32'h0;
   assign dbg_state        = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random requests against a
// byte-array reference memory, with a word-wide data memory model driven by the DUT.
module tb_load_store_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   load_store_unit_if bus ();

   load_store_unit #(.MEM_BYTES(2048)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, posedge write.
   logic [31:0] dmem [512] = '{default: 32'h0};
   assign bus.mem_rd = dmem[bus.mem_addr[10:2]];
   always @(posedge clk) begin
      if (bus.mem_memwrite) dmem[bus.mem_addr[10:2]] <= bus.mem_wd;
   end

   // Reference memory as plain bytes.
   logic [7:0]  ref_mem [2048] = '{default: 8'h00};
   logic [31:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] base;
      base = {a[31:2], 2'b00};
      return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
   endfunction

   // Expected result of one request from the RV32I rules; applies stores to ref_mem.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd,
                        output int lat);
      int          size;
      bit          legal;
      logic [31:0] v;
      size  = 1 << f3[1:0];
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err   = !legal || (addr % size) != 0 || addr >= 2048;
      rd    = 32'h0;
      v     = 32'h0;
      if (err) begin
         lat = 1;
      end else if (!we) begin
         for (int i = 0; i < size; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
         if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
         rd  = v;
         lat = 2;
      end else begin
         for (int i = 0; i < size; i++) ref_mem[addr + i] = 8'((wd >> (8 * i)) & 32'hFF);
         lat = (size == 4) ? 2 : 3;
      end
   endtask

   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] obs_rdata);
      logic        exp_err;
      logic [31:0] exp_rd;
      int          exp_lat, lat, mw, mw_at, w;
      bit          got;
      model(we, f3, addr, wd, exp_err, exp_rd, exp_lat);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      w = 0;
      while (!bus.req_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      if (w >= 10) check({tag, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 0; mw = 0; mw_at = 0; got = 0; obs_rdata = 32'hx;
      for (int c = 1; c <= 8 && !got; c++) begin
         @(negedge clk);
         if (bus.mem_memwrite) begin
            mw++;
            mw_at = c;
         end
         if (bus.resp_valid) begin
            got = 1;
            lat = c;
            obs_rdata = bus.resp_rdata;
            check({tag, "_rdata"}, bus.resp_rdata, exp_rd);
            check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_memwrite_cycles"}, 32'(mw), (we && !exp_err) ? 32'd1 : 32'd0);
      check({tag, "_memwrite_at"}, 32'(mw_at), (we && !exp_err) ? 32'(exp_lat - 1) : 32'd0);
      if (we && !exp_err) check({tag, "_mem_word"}, dmem[addr[10:2]], ref_word(addr));
      @(negedge clk);
      check({tag, "_resp_pulse"}, 32'(bus.resp_valid), 32'd0);
      check({tag, "_rdata_hold"}, bus.resp_rdata, exp_rd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [31:0] r;
      logic [2:0]  bf3 [3];
      logic [31:0] baddr [3];
      logic [31:0] bexp [3];
      int          acc_cyc [3];
      int          naccept, nresp, sel;
      bit          acc;
      logic        e;
      int          l;
      logic        rwe;
      logic [2:0]  rf3;
      logic [31:0] raddr;

      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'h0);
      check("rst_resp_err", 32'(bus.resp_err), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wd", bus.mem_wd, 32'h0);
      check("rst_memwrite", 32'(bus.mem_memwrite), 32'd0);
      rst_n = 1'b1;

      // Word store/load round trip
      do_req("sw0", 1'b1, 3'b010, 32'd0, 32'hDACBF567, r);
      do_req("lw0", 1'b0, 3'b010, 32'd0, 32'h0, r);
      check("lw0_value", r, 32'hDACBF567);

      // Byte store merge
      do_req("sw4", 1'b1, 3'b010, 32'd4, 32'hCA30B91E, r);
      do_req("sb5", 1'b1, 3'b000, 32'd5, 32'h000000AB, r);
      do_req("lw4", 1'b0, 3'b010, 32'd4, 32'h0, r);
      check("lw4_value", r, 32'hCA30AB1E);

      // Extension and lane selection
      do_req("lb7", 1'b0, 3'b000, 32'd7, 32'h0, r);
      check("lb7_value", r, 32'hFFFFFFCA);
      do_req("lbu7", 1'b0, 3'b100, 32'd7, 32'h0, r);
      check("lbu7_value", r, 32'h000000CA);
      do_req("lb6", 1'b0, 3'b000, 32'd6, 32'h0, r);
      check("lb6_value", r, 32'h00000030);
      do_req("lh6", 1'b0, 3'b001, 32'd6, 32'h0, r);
      check("lh6_value", r, 32'hFFFFCA30);
      do_req("lhu4", 1'b0, 3'b101, 32'd4, 32'h0, r);
      check("lhu4_value", r, 32'h0000AB1E);

      // Error paths
      do_req("err_lw2", 1'b0, 3'b010, 32'd2, 32'h0, r);
      do_req("err_sh3", 1'b1, 3'b001, 32'd3, 32'h5555, r);
      do_req("err_lw2048", 1'b0, 3'b010, 32'd2048, 32'h0, r);
      do_req("err_f3_011", 1'b0, 3'b011, 32'd0, 32'h0, r);
      do_req("err_sbu", 1'b1, 3'b100, 32'd8, 32'h77, r);
      check("err_mem0_unchanged", dmem[0], 32'hDACBF567);
      check("err_mem1_unchanged", dmem[1], 32'hCA30AB1E);

      // Reset during WRITE of a half-word store
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b001;
      bus.req_addr   = 32'd6;
      bus.req_wdata  = 32'h00001234;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rstmid_write_strobe", 32'(bus.mem_memwrite), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_memwrite_drop", 32'(bus.mem_memwrite), 32'd0);
      check("rstmid_req_ready", 32'(bus.req_ready), 32'd1);
      check("rstmid_resp_valid", 32'(bus.resp_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rstmid_mem_word", dmem[1], 32'hCA30AB1E);
      do_req("rstmid_lw4", 1'b0, 3'b010, 32'd4, 32'h0, r);
      check("rstmid_lw4_value", r, 32'hCA30AB1E);

      // Back-to-back loads with req_valid held high
      bf3   = '{3'b010, 3'b101, 3'b000};
      baddr = '{32'd0, 32'd4, 32'd7};
      for (int i = 0; i < 3; i++) model(1'b0, bf3[i], baddr[i], 32'h0, e, bexp[i], l);
      naccept = 0;
      nresp   = 0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_funct3 = bf3[0];
      bus.req_addr   = baddr[0];
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (bus.resp_valid) begin
            nresp++;
            if (exp_q.size() > 0) check("b2b_rdata", bus.resp_rdata, exp_q.pop_front());
            else                  check("b2b_extra_resp", 32'(bus.resp_valid), 32'd0);
         end
         acc = bus.req_valid && bus.req_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            acc_cyc[naccept] = cyc;
            exp_q.push_back(bexp[naccept]);
            naccept++;
            if (naccept < 3) begin
               bus.req_funct3 = bf3[naccept];
               bus.req_addr   = baddr[naccept];
            end else begin
               bus.req_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      check("b2b_accepts", 32'(naccept), 32'd3);
      check("b2b_responses", 32'(nresp), 32'd3);
      check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
      if (naccept == 3) begin
         check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
         check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
      end

      // Random requests
      for (int n = 0; n < 300; n++) begin
         rwe = 1'($urandom_range(0, 1));
         rf3 = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 9);
         if (sel == 0)      raddr = 32'd2048 + 32'($urandom_range(0, 4095));
         else if (sel == 1) raddr = 32'hFFFF_FFFC;
         else if (sel < 5)  raddr = 32'($urandom_range(0, 2047));
         else               raddr = 32'($urandom_range(0, 2047)) & ~((32'd1 << rf3[1:0]) - 32'd1);
         do_req($sformatf("rnd%0d", n), rwe, rf3, raddr, $urandom, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
